vending_machine_param: RTL and testbench
========================================

// Module: vending_machine_param
// PURPOSE
//   Parametrised multi-product vending controller; successor to the fixed two-output vending FSM.
//   Accumulates coin credit and vends one of NUM_PROD products, each with its own price.
//   Pays change serially, one CHANGE_UNIT per cycle; supports cancel/refund and rejects coins on overflow.
//   Sits between the coin acceptor / keypad front end and the dispenser / change hopper drivers.
// PARAMETERS
//   CREDIT_W     8                             width of credit and price values (units: 1 cent)
//   NUM_PROD     4                             number of selectable products (>=2)
//   PRICES       {8'd50,8'd25,8'd20,8'd15}     packed; price[i] = PRICES[i*CREDIT_W +: CREDIT_W]
//   COIN1_VAL    5                             value of coin code 2'b01
//   COIN2_VAL    10                            value of coin code 2'b10
//   COIN3_VAL    25                            value of coin code 2'b11
//   CHANGE_UNIT  5                             value paid per chg_pulse
//   MAX_CREDIT   100                           credit ceiling (< 2**CREDIT_W)
//   localparam SEL_W = $clog2(NUM_PROD)
// PORTS
//   clk       in   1         system clock, rising edge
//   rst       in   1         asynchronous, active-low reset
//   coin      in   2         coin code, one coin per cycle; 2'b00 = none
//   sel       in   SEL_W     product index, sampled with vend_req
//   vend_req  in   1         vend request, level sampled at each edge
//   cancel    in   1         refund all credit
//   dispense  out  1         1-cycle pulse: release product prod_id
//   prod_id   out  SEL_W     product being dispensed, valid with dispense
//   chg_pulse out  1         1-cycle pulse per CHANGE_UNIT returned
//   coin_rej  out  1         1-cycle pulse: coin sampled this edge was not credited
//   busy      out  1         high in DISPENSE/CHANGE
//   credit    out  CREDIT_W  current credit
// BEHAVIOUR
//   - All outputs registered. Reset (rst=0, async): state=IDLE, credit=0, all outputs 0.
//   - Reset mid-operation aborts: credit discarded, no further pulses.
//   - FSM states: IDLE, DISPENSE, CHANGE.
//   - IDLE, per edge, priority cancel > vend_req > coin:
//       cancel: credit>0 -> CHANGE; credit==0 -> stay IDLE.
//       vend_req, sel<NUM_PROD, credit>=price[sel]:
//         credit <= credit-price; prod_id <= sel; go DISPENSE.
//       vend_req, credit<price or sel>=NUM_PROD: ignored, credit unchanged.
//       coin!=0, no cancel/vend_req, credit+val<=MAX_CREDIT: credit += val.
//       Any other coin!=0: coin_rej=1 next cycle, credit unchanged.
//         Covers overflow, and a coin in the same cycle as cancel or vend_req.
//   - DISPENSE: dispense=1 for exactly this one cycle.
//       Next state: CHANGE if credit>0, else IDLE.
//   - CHANGE: each cycle chg_pulse=1 and credit -= CHANGE_UNIT.
//       Return to IDLE on the edge where credit reaches 0.
//   - Latency: accepting edge k -> dispense high during cycle k+1 -> first chg_pulse in cycle k+2.
//   - busy=1 in DISPENSE/CHANGE. In those states coin!=0 gives coin_rej; vend_req/cancel are ignored.
//   - Width: additions compared in CREDIT_W+1 bits; no wrap-around is possible.
//   - Legality (elaboration-time check, $error):
//       all prices, coin values and MAX_CREDIT are multiples of CHANGE_UNIT;
//       MAX_CREDIT < 2**CREDIT_W.
// STRUCTURE
//   - Package vending_pkg: state enum {IDLE, DISPENSE, CHANGE}; coin code constants
//     COIN_NONE/COIN_1/COIN_2/COIN_3.
//   - Sub-module vend_coin_decode: coin code -> CREDIT_W value + valid (combinational).
//   - Top: FSM, credit register, price mux from PRICES, output registers.
// TESTING (defaults)
//   1. Reset; coins 11,10 -> credit=35; vend_req sel=1 ->
//      dispense 1 cycle prod_id=1, credit=15, then 3 chg_pulse, credit=0, busy=0.
//   2. Exact payment: coins 10,01 (15); vend_req sel=0 -> dispense; no chg_pulse; IDLE next cycle.
//   3. Short credit: coin 01; vend_req sel=3 (50) -> no dispense, credit=5.
//      Then cancel -> 1 chg_pulse, credit=0.
//   4. Overflow: four coin 11 -> credit=100; fifth 11 -> coin_rej, credit=100.
//      coin 01 during CHANGE -> coin_rej.
//   5. Same edge, credit=30: cancel=1, vend_req=1 sel=0, coin=10 ->
//      coin_rej, no dispense, 6 chg_pulse.
//   6. Credit=25, vend sel=0, rst=0 after first chg_pulse ->
//      all outputs 0 immediately, credit=0, no more pulses after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and coin codes for the parametrised vending controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_3    = 2'b11;

    function automatic bit is_mult(input int val, input int unit);
        return (unit > 0) && ((val % unit) == 0);
    endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// Front-end (coin/keypad) to controller to dispenser/hopper signal bundle.
// No flow control: inputs are sampled every edge, outputs are single-cycle pulses.
interface vending_machine_param_if #(
    parameter int SEL_W    = 2,
    parameter int CREDIT_W = 8
);
    logic [1:0]          coin;
    logic [SEL_W-1:0]    sel;
    logic                vend_req;
    logic                cancel;
    logic                dispense;
    logic [SEL_W-1:0]    prod_id;
    logic                chg_pulse;
    logic                coin_rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin, sel, vend_req, cancel,
        input  dispense, prod_id, chg_pulse, coin_rej, busy, credit
    );

    modport slave (
        input  coin, sel, vend_req, cancel,
        output dispense, prod_id, chg_pulse, coin_rej, busy, credit
    );
endinterface

// File: rtl/vend_coin_decode.sv
// Maps a 2-bit coin code to its credit value plus a valid flag.
// Purely combinational, zero latency; no backpressure.
module vend_coin_decode
    import vending_pkg::*;
#(
    parameter int CREDIT_W  = 8,
    parameter int COIN1_VAL = 5,
    parameter int COIN2_VAL = 10,
    parameter int COIN3_VAL = 25
) (
    input  logic [1:0]          coin_i,
    output logic [CREDIT_W-1:0] val_o,
    output logic                vld_o
);

    always_comb begin
        val_o = '0;
        vld_o = 1'b0;
        case (coin_i)
            COIN_1: begin val_o = CREDIT_W'(COIN1_VAL); vld_o = 1'b1; end
            COIN_2: begin val_o = CREDIT_W'(COIN2_VAL); vld_o = 1'b1; end
            COIN_3: begin val_o = CREDIT_W'(COIN3_VAL); vld_o = 1'b1; end
            default: begin val_o = '0; vld_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/vending_machine_param.sv
// Multi-product vending FSM: credit accumulation, priced vend, serial change, refund.
// Accept edge k -> dispense in cycle k+1 -> change pulses from k+2; coins rejected while busy.
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int                             CREDIT_W    = 8,
    parameter int                             NUM_PROD    = 4,
    parameter logic [NUM_PROD*CREDIT_W-1:0]   PRICES      = {8'd50, 8'd25, 8'd20, 8'd15},
    parameter int                             COIN1_VAL   = 5,
    parameter int                             COIN2_VAL   = 10,
    parameter int                             COIN3_VAL   = 25,
    parameter int                             CHANGE_UNIT = 5,
    parameter int                             MAX_CREDIT  = 100,
    localparam int                            SEL_W       = $clog2(NUM_PROD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vending_machine_param_if.slave bus
);

    localparam logic [CREDIT_W:0]   MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CU    = CREDIT_W'(CHANGE_UNIT);

    generate
        if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max
            $error("MAX_CREDIT does not fit in CREDIT_W bits");
        end
        if (!is_mult(MAX_CREDIT, CHANGE_UNIT) || !is_mult(COIN1_VAL, CHANGE_UNIT) ||
            !is_mult(COIN2_VAL, CHANGE_UNIT) || !is_mult(COIN3_VAL, CHANGE_UNIT)) begin : g_bad_coin
            $error("coin values and MAX_CREDIT must be multiples of CHANGE_UNIT");
        end
        for (genvar gi = 0; gi < NUM_PROD; gi++) begin : g_price_chk
            if (!is_mult(int'(PRICES[gi*CREDIT_W +: CREDIT_W]), CHANGE_UNIT)) begin : g_bad_price
                $error("product price must be a multiple of CHANGE_UNIT");
            end
        end
    endgenerate

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    prod_id_q, prod_id_d;
    logic                dispense_q, dispense_d;
    logic                chg_pulse_q, chg_pulse_d;
    logic                coin_rej_q, coin_rej_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_vld;
    logic [CREDIT_W-1:0] price_sel;
    logic                sel_ok;
    logic [CREDIT_W:0]   sum;

    vend_coin_decode #(
        .CREDIT_W  (CREDIT_W),
        .COIN1_VAL (COIN1_VAL),
        .COIN2_VAL (COIN2_VAL),
        .COIN3_VAL (COIN3_VAL)
    ) u_coin_decode (
        .coin_i (bus.coin),
        .val_o  (coin_val),
        .vld_o  (coin_vld)
    );

    // Equality match rather than a range test so out-of-range selects fall through cleanly.
    always_comb begin
        price_sel = '0;
        sel_ok    = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_ok    = 1'b1;
            end
        end
    end

    assign sum = {1'b0, credit_q} + {1'b0, coin_val};

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        prod_id_d  = '0;
        coin_rej_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cancel) begin
                    coin_rej_d = coin_vld;
                    if (credit_q != '0) state_d = CHANGE;
                end else if (bus.vend_req) begin
                    coin_rej_d = coin_vld;
                    if (sel_ok && (credit_q >= price_sel)) begin
                        credit_d  = credit_q - price_sel;
                        prod_id_d = bus.sel;
                        state_d   = DISPENSE;
                    end
                end else if (coin_vld) begin
                    if (sum <= MAX_C) credit_d   = sum[CREDIT_W-1:0];
                    else              coin_rej_d = 1'b1;
                end
            end
            DISPENSE: begin
                coin_rej_d = coin_vld;
                state_d    = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // The pulse for this cycle pays out one unit; leave on the edge that empties credit.
                coin_rej_d = coin_vld;
                if (credit_q <= CU) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - CU;
                end
            end
            default: state_d = IDLE;
        endcase
        dispense_d  = (state_d == DISPENSE);
        chg_pulse_d = (state_d == CHANGE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            prod_id_q   <= '0;
            dispense_q  <= 1'b0;
            chg_pulse_q <= 1'b0;
            coin_rej_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            prod_id_q   <= prod_id_d;
            dispense_q  <= dispense_d;
            chg_pulse_q <= chg_pulse_d;
            coin_rej_q  <= coin_rej_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dispense  = dispense_q;
    assign bus.prod_id   = prod_id_q;
    assign bus.chg_pulse = chg_pulse_q;
    assign bus.coin_rej  = coin_rej_q;
    assign bus.busy      = busy_q;
    assign bus.credit    = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed scoreboard bench for vending_machine_param with default parameters.
module tb_vending_machine_param;
    import vending_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [31:0] disp_q[$];
    logic [31:0] chg_q[$];
    logic [31:0] rej_q[$];

    vending_machine_param_if #(.SEL_W(2), .CREDIT_W(8)) bus ();

    vending_machine_param dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [1:0] c, input logic v, input logic [1:0] s, input logic cn);
        bus.coin     = c;
        bus.vend_req = v;
        bus.sel      = s;
        bus.cancel   = cn;
        @(negedge clk);
        bus.coin     = COIN_NONE;
        bus.vend_req = 1'b0;
        bus.sel      = 2'd0;
        bus.cancel   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (bus.busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(bus.busy), 0);
    endtask

    // Scoreboard monitor: every output pulse must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.dispense === 1'b1) begin
                chk("disp_expected", 32'(disp_q.size() != 0), 1);
                if (disp_q.size() != 0) chk("disp_prod_id", 32'(bus.prod_id), disp_q.pop_front());
                chk("disp_busy", 32'(bus.busy), 1);
            end
            if (bus.chg_pulse === 1'b1) begin
                chk("chg_expected", 32'(chg_q.size() != 0), 1);
                if (chg_q.size() != 0) chk("chg_busy", 32'(bus.busy), chg_q.pop_front());
            end
            if (bus.coin_rej === 1'b1) begin
                chk("rej_expected", 32'(rej_q.size() != 0), 1);
                if (rej_q.size() != 0) chk("rej_busy", 32'(bus.busy), rej_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.coin = COIN_NONE; bus.vend_req = 1'b0; bus.sel = 2'd0; bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_credit", 32'(bus.credit), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_dispense", 32'(bus.dispense), 0);
        chk("rst_chg", 32'(bus.chg_pulse), 0);
        chk("rst_rej", 32'(bus.coin_rej), 0);
        chk("rst_prod_id", 32'(bus.prod_id), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 35 cents, buy product 1 (20), three change pulses
        apply(COIN_3, 1'b0, 2'd0, 1'b0);
        apply(COIN_2, 1'b0, 2'd0, 1'b0);
        chk("t1_credit35", 32'(bus.credit), 35);
        disp_q.push_back(1);
        repeat (3) chg_q.push_back(1);
        apply(COIN_NONE, 1'b1, 2'd1, 1'b0);
        chk("t1_dispense", 32'(bus.dispense), 1);
        chk("t1_credit15", 32'(bus.credit), 15);
        @(negedge clk);
        chk("t1_first_chg_k2", 32'(bus.chg_pulse), 1);
        wait_idle(20);
        chk("t1_credit0", 32'(bus.credit), 0);

        // 2: exact payment for product 0 (15)
        apply(COIN_2, 1'b0, 2'd0, 1'b0);
        apply(COIN_1, 1'b0, 2'd0, 1'b0);
        chk("t2_credit15", 32'(bus.credit), 15);
        disp_q.push_back(0);
        apply(COIN_NONE, 1'b1, 2'd0, 1'b0);
        chk("t2_busy", 32'(bus.busy), 1);
        chk("t2_credit0", 32'(bus.credit), 0);
        @(negedge clk);
        chk("t2_idle_next", 32'(bus.busy), 0);
        chk("t2_no_chg", 32'(bus.chg_pulse), 0);

        // 3: short credit for product 3 (50), then cancel
        apply(COIN_1, 1'b0, 2'd0, 1'b0);
        apply(COIN_NONE, 1'b1, 2'd3, 1'b0);
        chk("t3_no_dispense", 32'(bus.dispense), 0);
        chk("t3_credit5", 32'(bus.credit), 5);
        chk("t3_not_busy", 32'(bus.busy), 0);
        chg_q.push_back(1);
        apply(COIN_NONE, 1'b0, 2'd0, 1'b1);
        wait_idle(10);
        chk("t3_credit0", 32'(bus.credit), 0);

        // 4: fill to ceiling, overflow reject, then reject during refund
        repeat (4) apply(COIN_3, 1'b0, 2'd0, 1'b0);
        chk("t4_credit100", 32'(bus.credit), 100);
        rej_q.push_back(0);
        apply(COIN_3, 1'b0, 2'd0, 1'b0);
        chk("t4_rej", 32'(bus.coin_rej), 1);
        chk("t4_credit_hold", 32'(bus.credit), 100);
        repeat (20) chg_q.push_back(1);
        apply(COIN_NONE, 1'b0, 2'd0, 1'b1);
        rej_q.push_back(1);
        apply(COIN_1, 1'b0, 2'd0, 1'b0);
        chk("t4_rej_in_change", 32'(bus.coin_rej), 1);
        wait_idle(40);
        chk("t4_credit0", 32'(bus.credit), 0);

        // 5: cancel + vend + coin on the same edge with 30 cents
        apply(COIN_3, 1'b0, 2'd0, 1'b0);
        apply(COIN_1, 1'b0, 2'd0, 1'b0);
        chk("t5_credit30", 32'(bus.credit), 30);
        rej_q.push_back(1);
        repeat (6) chg_q.push_back(1);
        apply(COIN_2, 1'b1, 2'd0, 1'b1);
        chk("t5_rej", 32'(bus.coin_rej), 1);
        chk("t5_no_dispense", 32'(bus.dispense), 0);
        wait_idle(20);
        chk("t5_credit0", 32'(bus.credit), 0);

        // 6: reset during change payout
        apply(COIN_3, 1'b0, 2'd0, 1'b0);
        disp_q.push_back(0);
        chg_q.push_back(1);
        apply(COIN_NONE, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        chk("t6_chg_before_rst", 32'(bus.chg_pulse), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_chg", 32'(bus.chg_pulse), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_credit", 32'(bus.credit), 0);
        chk("t6_rst_dispense", 32'(bus.dispense), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_credit_after", 32'(bus.credit), 0);

        chk("disp_q_empty", 32'(disp_q.size()), 0);
        chk("chg_q_empty", 32'(chg_q.size()), 0);
        chk("rej_q_empty", 32'(rej_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
